pca_proj_sequencer: RTL
=======================

Name: pca_proj_sequencer

Overview:
Sequenced, synthesizable replacement for the combinational PCA projection stage of the IDS pipeline. Accepts one feature vector of PC_NUM elements over a valid/ready stream and buffers it. Time-multiplexes a single multiply-accumulate (MAC) over MIN_PC_NUM coefficient rows, fetched from an external synchronous coefficient ROM. Emits MIN_PC_NUM projected values, one per beat, to the downstream classifier.

Parameters:
DATA_W, 32, signed fixed-point width of inputs, coefficients and outputs
FRAC_W, 16, fractional bits; product rescaled by >>FRAC_W
PC_NUM, 32, vector length (columns per coefficient row)
MIN_PC_NUM, 5, number of principal components (rows)
ADDR_W, $clog2(PC_NUM*MIN_PC_NUM), coefficient ROM address width
IDX_W, $clog2(MIN_PC_NUM) (min 1), output index width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  input element valid
in_ready  out  1  high in LOAD only
in_data  in  DATA_W  feature element, index 0 first
coef_rd_en  out  1  ROM read strobe
coef_addr  out  ADDR_W  row*PC_NUM+col
coef_data  in  DATA_W  ROM data, valid one cycle after coef_rd_en
out_valid  out  1  result valid
out_ready  in  1  downstream accept
out_data  out  DATA_W  projected component
out_idx  out  IDX_W  component index
out_last  out  1  high with idx MIN_PC_NUM-1
busy  out  1  high in COMPUTE or OUT

Behaviour:
- Single clock, clk; reset asynchronous active-low on reset_n. All state and counters clear while reset_n is low.
- Reset values: state=LOAD; out_valid=0; coef_rd_en=0; coef_addr=0; out_data=0; out_idx=0; out_last=0; busy=0.
- in_ready is a combinational decode of state==LOAD. No beat is accepted while reset_n=0.
- LOAD:
  - A beat completes on in_valid&in_ready and is stored at vec[col_cnt]; col_cnt then increments.
  - On the beat with col_cnt==PC_NUM-1, go to COMPUTE and clear the counters.
  - in_valid gaps are tolerated.
- COMPUTE:
  - Issue one read per cycle for k=0..N-1, where N=MIN_PC_NUM*PC_NUM. coef_rd_en=1, coef_addr=k, row/col counters wrap col at PC_NUM.
  - The MAC consumes coef_data one cycle later against the registered vec[col].
  - The accumulator clears at column 0 of each row. The first product of a row is loaded rather than added.
  - At a row's last product, the rescaled result is written to res[row].
  - After the final product, go to OUT.
  - Latency: out_valid rises N+1 clock edges after the edge accepting the last input (defaults: 161).
- OUT:
  - Present res[out_idx], with out_valid=1 and out_last=(out_idx==MIN_PC_NUM-1).
  - Advance out_idx on out_valid&out_ready. Data and index stay stable while out_ready=0.
  - After the last beat is accepted, return to LOAD the next cycle with out_valid=0.
- Arithmetic:
  - product = signed DATA_W x DATA_W → 2*DATA_W.
  - acc width = 2*DATA_W+$clog2(PC_NUM), so it cannot overflow.
  - result = acc>>>FRAC_W, reduced to DATA_W per the Optional Feature.
- Back-to-back frames: the next frame's input is not accepted until OUT completes; there is no overlap.
- Reset mid-operation: aborts immediately. Buffered and partial results are discarded and no out_valid is produced.

Optional Feature:
PCA_PROJ_SAT_EN
- Defined: the rescaled result is saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Undefined: the result is truncated to its low DATA_W bits (two's-complement wrap).
- Port list is identical in both builds.

Decomposition:
- Package pca_proj_pkg holds:
  - state enum {LOAD, COMPUTE, OUT}
  - default DATA_W/FRAC_W constants
  - acc-width function
  - sat/truncate function, selected by PCA_PROJ_SAT_EN
- Sub-module pca_mac_unit:
  - ports: clk, reset_n, en, clr_first, a, b, acc_out
  - contains the registered multiply plus accumulate-with-load.
- Sequencer keeps the FSM, counters, vec/res buffers and handshakes.

Test Plan:
All tests use DATA_W=16, FRAC_W=0, PC_NUM=4, MIN_PC_NUM=2 unless noted.
- Basic: vec [1,2,3,4]; ROM rows [1,1,1,1],[-1,0,2,0] → beats (idx0,10),(idx1,5,last=1); out_valid rises 9 edges after the last input beat.
- Backpressure: same frame with out_ready low 3 cycles at idx0 → out_data=10 and out_idx=0 held stable; no beat lost; in_ready=0 throughout OUT.
- Input gaps: in_valid toggling 1,0,0,1,... for vec [1,2,3,4] → identical results; in_ready=0 from the edge after the 4th beat.
- Saturation: vec all 32767; ROM row0 all 32767 → with PCA_PROJ_SAT_EN out_data=32767; without it out_data=4 (low 16 bits of 0xFFFC0004).
- Reset mid-COMPUTE: reset_n low for 2 cycles at the 3rd COMPUTE cycle → out_valid and coef_rd_en go to 0 asynchronously; after release in_ready=1; next frame [2,0,0,0] gives (2,-2).
- Back-to-back frames: two frames sent consecutively with out_ready=1 → second frame accepted only after out_last beat; four correct results in order.

Source files
------------

// File: rtl/pca_proj_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pca_proj_pkg
// Purpose  : Shared types, defaults and result-reduction helpers for the PCA
//            projection sequencer. PCA_PROJ_SAT_EN selects saturation instead
//            of two's-complement wrap when reducing results to DATA_W.
// Revision : 1.0 - initial release
// ============================================================================
package pca_proj_pkg;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        OUT     = 2'd2
    } state_t;

    localparam int c_DATA_W_DEF = 32;
    localparam int c_FRAC_W_DEF = 16;
    // Widest intermediate handled by reduce_result; covers any sane DATA_W/PC_NUM.
    localparam int c_WIDE_W     = 128;

    function automatic int acc_width(input int data_w, input int pc_num);
        return 2 * data_w + $clog2(pc_num);
    endfunction

    // Reduces a rescaled accumulator to its low 'width' bits (wrap) or to the
    // signed range of 'width' bits (saturate).
    function automatic logic [c_WIDE_W-1:0] reduce_result(input logic signed [c_WIDE_W-1:0] val,
                                                          input int width);
`ifdef PCA_PROJ_SAT_EN
        logic signed [c_WIDE_W-1:0] w_max;
        logic signed [c_WIDE_W-1:0] w_min;
        w_max = (c_WIDE_W'(1) << (width - 1)) - c_WIDE_W'(1);
        w_min = ~w_max;
        if (val > w_max) begin
            return w_max;
        end
        if (val < w_min) begin
            return w_min;
        end
        return val;
`else
        logic [c_WIDE_W-1:0] w_mask;
        w_mask = (c_WIDE_W'(1) << width) - c_WIDE_W'(1);
        return val & w_mask;
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/pca_mac_unit.sv
`default_nettype none
// ============================================================================
// Module   : pca_mac_unit
// Purpose  : Signed multiply into a registered accumulator; clr_first loads the
//            product instead of adding it. Unaffected by PCA_PROJ_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pca_mac_unit
    import pca_proj_pkg::*;
#(
    parameter int DATA_W = c_DATA_W_DEF,
    parameter int ACC_W  = acc_width(c_DATA_W_DEF, 32)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     en,
    input  logic                     clr_first,
    input  logic [DATA_W-1:0]        a,
    input  logic [DATA_W-1:0]        b,
    output logic signed [ACC_W-1:0]  acc_out
);

    localparam int c_PROD_W = 2 * DATA_W;

    logic signed [c_PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [ACC_W-1:0]    r_acc;

    assign w_prod     = c_PROD_W'($signed(a)) * c_PROD_W'($signed(b));
    assign w_prod_ext = ACC_W'(w_prod);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= clr_first ? w_prod_ext : (r_acc + w_prod_ext);
        end
    end

    assign acc_out = r_acc;

endmodule
`default_nettype wire

// File: rtl/pca_proj_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pca_proj_sequencer
// Purpose  : Buffers one PC_NUM-element vector, projects it onto MIN_PC_NUM
//            ROM coefficient rows with one shared MAC, streams the results.
//            PCA_PROJ_SAT_EN: saturate results instead of wrapping them.
// Revision : 1.0 - initial release
// ============================================================================
module pca_proj_sequencer
    import pca_proj_pkg::*;
#(
    parameter int DATA_W     = c_DATA_W_DEF,
    parameter int FRAC_W     = c_FRAC_W_DEF,
    parameter int PC_NUM     = 32,
    parameter int MIN_PC_NUM = 5,
    parameter int ADDR_W     = $clog2(PC_NUM * MIN_PC_NUM),
    parameter int IDX_W      = (MIN_PC_NUM > 1) ? $clog2(MIN_PC_NUM) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              coef_rd_en,
    output logic [ADDR_W-1:0] coef_addr,
    input  logic [DATA_W-1:0] coef_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              busy
);

    localparam int                 c_ACC_W    = acc_width(DATA_W, PC_NUM);
    localparam int                 c_COL_W    = (PC_NUM > 1) ? $clog2(PC_NUM) : 1;
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(PC_NUM - 1);
    localparam logic [IDX_W-1:0]   c_ROW_LAST = IDX_W'(MIN_PC_NUM - 1);

    state_t              r_state;
    logic [c_COL_W-1:0]  r_col;
    logic [IDX_W-1:0]    r_row;
    logic [DATA_W-1:0]   r_vec [PC_NUM];
    logic [DATA_W-1:0]   r_res [MIN_PC_NUM];
    logic                r_rd_en;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_mac_en;
    logic [c_COL_W-1:0]  r_mac_col;
    logic [IDX_W-1:0]    r_mac_row;
    logic                r_wr_en;
    logic [IDX_W-1:0]    r_wr_row;
    logic                r_out_valid;
    logic [IDX_W-1:0]    r_out_idx;

    logic signed [c_ACC_W-1:0]  w_acc;
    logic signed [c_WIDE_W-1:0] w_acc_wide;
    logic [DATA_W-1:0]          w_acc_res;

    // ROM data for the read issued last cycle meets the matching vec column.
    pca_mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (c_ACC_W)
    ) u_mac (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (r_mac_en),
        .clr_first (r_mac_col == '0),
        .a         (r_vec[r_mac_col]),
        .b         (coef_data),
        .acc_out   (w_acc)
    );

    assign w_acc_wide = c_WIDE_W'(w_acc);
    assign w_acc_res  = DATA_W'(reduce_result(w_acc_wide >>> FRAC_W, DATA_W));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= LOAD;
            r_col       <= '0;
            r_row       <= '0;
            r_rd_en     <= 1'b0;
            r_addr      <= '0;
            r_mac_en    <= 1'b0;
            r_mac_col   <= '0;
            r_mac_row   <= '0;
            r_wr_en     <= 1'b0;
            r_wr_row    <= '0;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            for (int i = 0; i < PC_NUM; i++) begin
                r_vec[i] <= '0;
            end
            for (int i = 0; i < MIN_PC_NUM; i++) begin
                r_res[i] <= '0;
            end
        end else begin
            r_mac_en  <= r_rd_en;
            r_mac_col <= r_col;
            r_mac_row <= r_row;
            r_wr_en   <= r_mac_en && (r_mac_col == c_COL_LAST);
            r_wr_row  <= r_mac_row;
            if (r_wr_en) begin
                r_res[r_wr_row] <= w_acc_res;
            end

            case (r_state)
                LOAD: begin
                    if (in_valid) begin
                        r_vec[r_col] <= in_data;
                        if (r_col == c_COL_LAST) begin
                            r_col   <= '0;
                            r_row   <= '0;
                            r_addr  <= '0;
                            r_rd_en <= 1'b1;
                            r_state <= COMPUTE;
                        end else begin
                            r_col <= r_col + c_COL_W'(1);
                        end
                    end
                end
                COMPUTE: begin
                    if (r_rd_en) begin
                        if (r_col == c_COL_LAST) begin
                            r_col <= '0;
                            if (r_row == c_ROW_LAST) begin
                                r_rd_en <= 1'b0;
                            end else begin
                                r_row  <= r_row + IDX_W'(1);
                                r_addr <= r_addr + ADDR_W'(1);
                            end
                        end else begin
                            r_col  <= r_col + c_COL_W'(1);
                            r_addr <= r_addr + ADDR_W'(1);
                        end
                    end
                    if (r_mac_en && (r_mac_col == c_COL_LAST) && (r_mac_row == c_ROW_LAST)) begin
                        r_state     <= OUT;
                        r_out_valid <= 1'b1;
                        r_out_idx   <= '0;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        if (r_out_idx == c_ROW_LAST) begin
                            r_out_valid <= 1'b0;
                            r_out_idx   <= '0;
                            r_col       <= '0;
                            r_row       <= '0;
                            r_state     <= LOAD;
                        end else begin
                            r_out_idx <= r_out_idx + IDX_W'(1);
                        end
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

    // The last row is read straight from the held accumulator: its res[] slot
    // is only written one cycle after out_valid has already risen.
    assign out_data   = (r_out_idx == c_ROW_LAST) ? w_acc_res : r_res[r_out_idx];
    assign in_ready   = (r_state == LOAD);
    assign busy       = (r_state != LOAD);
    assign coef_rd_en = r_rd_en;
    assign coef_addr  = r_addr;
    assign out_valid  = r_out_valid;
    assign out_idx    = r_out_idx;
    assign out_last   = r_out_valid && (r_out_idx == c_ROW_LAST);

endmodule
`default_nettype wire
